// File: rtl/atm_terminal_arbiter.sv
// atm_terminal_arbiter
//   Shares one ATM transaction engine among N_TERM card terminals. A
//   round-robin arbiter picks one requesting terminal, latches its request
//   fields, pulses the engine start, waits for the engine result (guarded by a
//   watchdog), and returns the result to the winning terminal only.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req / req_*              per-terminal request and packed request fields
//   gnt                      one-hot grant, held from grant through the response cycle
//   rsp_valid                one-cycle pulse to the granted terminal
//   rsp_success/balance/timeout  result, valid with rsp_valid
//   busy                     high whenever a transaction is in progress
//   eng_start, eng_*         start pulse and latched request fields to the engine
//   eng_done/success/balance engine result, sampled only while waiting
//
// state | meaning
// IDLE  | no transaction, arbitrate among requesters
// ISSUE | engine start pulse, watchdog cleared
// WAIT  | waiting for eng_done or watchdog expiry
// RESP  | rsp_valid to winner, pointer advances to winner
module atm_terminal_arbiter #(
  parameter int N_TERM  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_TERM-1:0]    req,
  input  logic [3*N_TERM-1:0]  req_op,
  input  logic [4*N_TERM-1:0]  req_acc,
  input  logic [16*N_TERM-1:0] req_pin,
  input  logic [16*N_TERM-1:0] req_newpin,
  input  logic [32*N_TERM-1:0] req_amount,
  output logic [N_TERM-1:0]    gnt,
  output logic [N_TERM-1:0]    rsp_valid,
  output logic                 rsp_success,
  output logic [31:0]          rsp_balance,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic                 eng_start,
  output logic [2:0]           eng_op,
  output logic [3:0]           eng_acc,
  output logic [15:0]          eng_pin,
  output logic [15:0]          eng_newpin,
  output logic [31:0]          eng_amount,
  input  logic                 eng_done,
  input  logic                 eng_success,
  input  logic [31:0]          eng_balance
);

  localparam int IW = $clog2(N_TERM);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_TERM-1:0] gnt_q, gnt_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        acc_q, acc_d;
  logic [15:0]       pin_q, pin_d;
  logic [15:0]       newpin_q, newpin_d;
  logic [31:0]       amt_q, amt_d;
  logic              succ_q, succ_d;
  logic [31:0]       bal_q, bal_d;
  logic              to_q, to_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [2:0]        sel_op;
  logic [3:0]        sel_acc;
  logic [15:0]       sel_pin;
  logic [15:0]       sel_newpin;
  logic [31:0]       sel_amt;

  // Search starts one past the last winner and wraps, so the last winner
  // is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= N_TERM; off++) begin
      cand = IW'((int'(ptr_q) + off) % N_TERM);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Field mux with constant slice bases.
  always_comb begin
    sel_op     = '0;
    sel_acc    = '0;
    sel_pin    = '0;
    sel_newpin = '0;
    sel_amt    = '0;
    for (int i = 0; i < N_TERM; i++) begin
      if (win_idx == IW'(i)) begin
        sel_op     = req_op[3*i +: 3];
        sel_acc    = req_acc[4*i +: 4];
        sel_pin    = req_pin[16*i +: 16];
        sel_newpin = req_newpin[16*i +: 16];
        sel_amt    = req_amount[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    pin_d    = pin_q;
    newpin_d = newpin_q;
    amt_d    = amt_q;
    succ_d   = succ_q;
    bal_d    = bal_q;
    to_d     = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_ISSUE;
          idx_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          op_d           = sel_op;
          acc_d          = sel_acc;
          pin_d          = sel_pin;
          newpin_d       = sel_newpin;
          amt_d          = sel_amt;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final watchdog cycle still counts as a real result.
        if (eng_done) begin
          succ_d  = eng_success;
          bal_d   = eng_balance;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          succ_d  = 1'b0;
          bal_d   = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = idx_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(N_TERM - 1);
      idx_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      pin_q    <= '0;
      newpin_q <= '0;
      amt_q    <= '0;
      succ_q   <= 1'b0;
      bal_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      pin_q    <= pin_d;
      newpin_q <= newpin_d;
      amt_q    <= amt_d;
      succ_q   <= succ_d;
      bal_q    <= bal_d;
      to_q     <= to_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = (state_q == S_RESP) ? gnt_q : '0;
  assign rsp_success = succ_q;
  assign rsp_balance = bal_q;
  assign rsp_timeout = to_q;
  assign busy        = (state_q != S_IDLE);
  assign eng_start   = (state_q == S_ISSUE);
  assign eng_op      = op_q;
  assign eng_acc     = acc_q;
  assign eng_pin     = pin_q;
  assign eng_newpin  = newpin_q;
  assign eng_amount  = amt_q;

endmodule

// File: tb/tb_atm_terminal_arbiter.sv
module tb_atm_terminal_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [3*N-1:0]  req_op;
  logic [4*N-1:0]  req_acc;
  logic [16*N-1:0] req_pin;
  logic [16*N-1:0] req_newpin;
  logic [32*N-1:0] req_amount;
  logic [N-1:0]    gnt, rsp_valid;
  logic            rsp_success, rsp_timeout, busy, eng_start;
  logic [31:0]     rsp_balance;
  logic [2:0]      eng_op;
  logic [3:0]      eng_acc;
  logic [15:0]     eng_pin, eng_newpin;
  logic [31:0]     eng_amount;
  logic            eng_done, eng_success;
  logic [31:0]     eng_balance;

  atm_terminal_arbiter #(.N_TERM(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acc(req_acc),
    .req_pin(req_pin), .req_newpin(req_newpin), .req_amount(req_amount),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_success(rsp_success),
    .rsp_balance(rsp_balance), .rsp_timeout(rsp_timeout), .busy(busy),
    .eng_start(eng_start), .eng_op(eng_op), .eng_acc(eng_acc), .eng_pin(eng_pin),
    .eng_newpin(eng_newpin), .eng_amount(eng_amount), .eng_done(eng_done),
    .eng_success(eng_success), .eng_balance(eng_balance)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a transaction is described by its age in
  // clock edges since the grant edge. Age 1 is the start cycle, ages
  // 2..T+1 are the T cycles in which an engine result is accepted, and the
  // cycle after the result (or after age T+1 expires) is the response cycle.
  bit          m_valid = 0;
  bit          m_active, m_resp, m_to, m_succ;
  int          m_age, m_win, m_ptr;
  logic [31:0] m_bal;
  logic [2:0]  m_op;
  logic [3:0]  m_acc;
  logic [15:0] m_pin, m_newpin;
  logic [31:0] m_amt;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_resp   = 0;
      m_ptr    = N - 1;
      m_age    = 0;
    end else if (m_active) begin
      if (m_resp) begin
        m_active = 0;
        m_resp   = 0;
        m_ptr    = m_win;
      end else begin
        if (m_age >= 2 && eng_done) begin
          m_resp = 1; m_to = 0; m_succ = eng_success; m_bal = eng_balance;
        end else if (m_age == T + 1) begin
          m_resp = 1; m_to = 1; m_succ = 0; m_bal = 0;
        end
        m_age++;
      end
    end else if (|req) begin
      int w;
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_win    = w;
      m_op     = req_op[3*w +: 3];
      m_acc    = req_acc[4*w +: 4];
      m_pin    = req_pin[16*w +: 16];
      m_newpin = req_newpin[16*w +: 16];
      m_amt    = req_amount[32*w +: 32];
      m_active = 1;
      m_age    = 1;
    end
  end

  logic [N-1:0] e_gnt, e_valid;

  always @(negedge clk) begin
    if (m_valid) begin
      e_gnt = '0;
      if (m_active) e_gnt[m_win] = 1'b1;
      e_valid = m_resp ? e_gnt : '0;
      chk("gnt", gnt, e_gnt);
      chk("rsp_valid", rsp_valid, e_valid);
      chk("busy", busy, m_active);
      chk("eng_start", eng_start, m_active && !m_resp && m_age == 1);
      if (m_resp) begin
        chk("rsp_success", rsp_success, m_succ);
        chk("rsp_balance", rsp_balance, m_bal);
        chk("rsp_timeout", rsp_timeout, m_to);
      end
      if (m_active) begin
        chk("eng_fields", {eng_op, eng_acc, eng_pin, eng_newpin}, {m_op, m_acc, m_pin, m_newpin});
        chk("eng_amount", eng_amount, m_amt);
      end
    end
  end

  // Engine: after a start, pulses eng_done plan_d cycles later (0 = never).
  bit          eng_rand = 0;
  int          plan_d   = 0;
  bit          plan_s   = 0;
  logic [31:0] plan_b   = '0;
  int          eng_cnt  = 0;

  initial begin
    eng_done = 0; eng_success = 0; eng_balance = '0;
    forever begin
      @(posedge clk); #2;
      eng_done    = 0;
      eng_success = 1'($urandom);
      eng_balance = $urandom;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1; eng_success = plan_s; eng_balance = plan_b;
        end
      end
      if (eng_start) begin
        if (eng_rand) begin
          plan_d = $urandom_range(0, 3) == 0 ? T + $urandom_range(0, 3) : $urandom_range(1, T);
          plan_s = 1'($urandom);
          plan_b = $urandom;
        end
        eng_cnt = plan_d;
      end
      if (eng_rand && $urandom_range(0, 23) == 0) eng_done = 1;
    end
  end

  // Random terminals: hold req until own response, sometimes mutate or drop
  // fields while granted (must be ignored by the arbiter).
  bit req_rand = 0;

  task automatic new_fields(input int i);
    req_op[3*i +: 3]       = 3'($urandom);
    req_acc[4*i +: 4]      = 4'($urandom);
    req_pin[16*i +: 16]    = 16'($urandom);
    req_newpin[16*i +: 16] = 16'($urandom);
    req_amount[32*i +: 32] = $urandom;
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      if (req_rand) begin
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i]) begin
            if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
            else new_fields(i);
          end else if (req[i]) begin
            if (gnt[i] && $urandom_range(0, 7) == 0) begin
              new_fields(i);
              if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            new_fields(i);
            req[i] = 1'b1;
          end
        end
      end
    end
  end

  // Returns #1 into the response cycle; lat counts cycles after the start cycle.
  task automatic run_until_rsp(output int st, output int lat, output logic [N-1:0] v);
    int n;
    st = 0; lat = -1; v = '0; n = 0;
    while (n < 80) begin
      @(posedge clk); #1;
      n++;
      if (eng_start) begin st++; lat = 0; end
      else if (lat >= 0) lat++;
      if (rsp_valid != '0) begin v = rsp_valid; break; end
    end
    if (v == '0) begin
      total++; bad++;
      $display("FAIL rsp_wait: no rsp_valid within 80 cycles at %0t", $time);
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!eng_start && n < 40);
    if (!eng_start) begin
      total++; bad++;
      $display("FAIL start_wait: no eng_start within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    int st, lat, ix;
    logic [N-1:0] v;
    int order_exp [7];
    order_exp = '{0, 2, 3, 0, 1, 2, 3};

    rst = 1; req = '0; req_op = '0; req_acc = '0; req_pin = '0;
    req_newpin = '0; req_amount = '0;
    @(posedge clk); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_fields", {eng_op, eng_acc, eng_pin, eng_newpin, eng_amount}, 0);
    chk("rst_rsp", {rsp_success, rsp_timeout, rsp_balance}, 0);
    @(posedge clk); #2; rst = 0;

    // Single transaction from terminal 0, done 3 cycles after start.
    req_op[2:0] = 3'd3; req_acc[3:0] = 4'd1; req_pin[15:0] = 16'd1234;
    req_amount[31:0] = 32'd0;
    plan_d = 3; plan_s = 1; plan_b = 32'd5000;
    req[0] = 1'b1;
    run_until_rsp(st, lat, v);
    chk("t1_valid", v, 4'b0001);
    chk("t1_starts", st, 1);
    chk("t1_latency", lat, 4);
    chk("t1_balance", rsp_balance, 32'd5000);
    chk("t1_success", rsp_success, 1);
    chk("t1_timeout", rsp_timeout, 0);
    chk("t1_op_pin", {eng_op, eng_pin}, {3'd3, 16'd1234});
    #1; req = '0;
    @(posedge clk); #1;
    chk("t1_pulse_once", rsp_valid, 0);

    // Round-robin order: 0101 held, then 1111 held.
    #1; rst = 1;
    @(posedge clk); #2; rst = 0;
    plan_d = 1; req = 4'b0101;
    for (int k = 0; k < 7; k++) begin
      run_until_rsp(st, lat, v);
      ix = -1;
      for (int b = 0; b < N; b++) if (v[b]) ix = b;
      chk("t2_order", ix, order_exp[k]);
      if (k == 1) req = 4'b1111;
    end

    // Watchdog: engine never answers. WAIT spans T cycles, so the response
    // cycle is T+1 cycles after the start cycle.
    req = 4'b0010; plan_d = 0;
    run_until_rsp(st, lat, v);
    chk("t3_valid", v, 4'b0010);
    chk("t3_latency", lat, T + 1);
    chk("t3_timeout", rsp_timeout, 1);
    chk("t3_success", rsp_success, 0);
    chk("t3_balance", rsp_balance, 0);

    // Done on the last watchdog cycle wins over the timeout.
    req = 4'b0100; plan_d = T; plan_s = 1; plan_b = 32'd900;
    run_until_rsp(st, lat, v);
    chk("t4_valid", v, 4'b0100);
    chk("t4_latency", lat, T + 1);
    chk("t4_timeout", rsp_timeout, 0);
    chk("t4_success", rsp_success, 1);
    chk("t4_balance", rsp_balance, 32'd900);

    // Reset mid-WAIT for terminal 2 with 0110 held.
    plan_d = 0;
    wait_start();
    chk("t5_gnt2", gnt, 4'b0100);
    req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t5_no_rsp", rsp_valid, 0);
    end
    #1; rst = 1;
    @(posedge clk); #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_gnt", gnt, 0);
    #1; rst = 0; plan_d = 2;
    run_until_rsp(st, lat, v);
    chk("t5_next_winner", v, 4'b0010);
    chk("t5_starts", st, 1);
    req = '0;

    // Winner changes amount after grant; latched value must persist.
    req_amount[31:0] = 32'd500; req[0] = 1'b1; plan_d = 5;
    wait_start();
    req_amount[31:0] = 32'd9999;
    run_until_rsp(st, lat, v);
    chk("t6_valid", v, 4'b0001);
    chk("t6_amount", eng_amount, 32'd500);
    req = '0;

    // Randomized traffic with occasional resets.
    @(posedge clk); #2;
    eng_rand = 1; req_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 299) == 0);
    end
    req_rand = 0; eng_rand = 0; rst = 1; req = '0;
    @(posedge clk); #2; rst = 0;
    repeat (5) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
